uart_tx_scheduler: RTL

//  Shares one simple_transmitter among NUM_CH source FIFOs (FWFT read ports).

---
 rtl/uart_tx_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Multiplexes NUM_CH first-word-fall-through source FIFOs onto one
//   transmitter input. Channels are granted round-robin, one burst of up
//   to MAX_BURST words per grant. When HEADER_EN is set, each burst is
//   preceded by a header word carrying the channel ID so that the far end
//   can demultiplex the stream.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   src_dout     packed source data, channel i at [i*WORD_WIDTH +: WORD_WIDTH]
//   src_empty    per-channel FIFO empty flags
//   src_re       per-channel read strobes (one-hot or zero)
//   tx_din       word offered to the transmitter
//   tx_empty     low when tx_din is valid
//   tx_re        transmitter consumes tx_din this cycle
//   grant_valid  high while a header or burst is in progress
//   grant_id     current / most recently granted channel
module uart_tx_scheduler #(
  parameter int                    NUM_CH     = 4,
  parameter int                    WORD_WIDTH = 8,
  parameter int                    MAX_BURST  = 16,
  parameter int                    HEADER_EN  = 1,
  parameter logic [WORD_WIDTH-1:0] HEADER_TAG = WORD_WIDTH'('hF0),
  localparam int                   ID_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*WORD_WIDTH-1:0] src_dout,
  input  logic [NUM_CH-1:0]            src_empty,
  output logic [NUM_CH-1:0]            src_re,
  output logic [WORD_WIDTH-1:0]        tx_din,
  output logic                         tx_empty,
  input  logic                         tx_re,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, HEADER, BURST} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Round-robin search: first non-empty channel after the pointer, wrapping.
  logic              found;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   cand;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_CH);
      if (!found && !src_empty[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tx_din   = '0;
    tx_empty = 1'b1;
    src_re   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          ptr_d   = sel;
          cnt_d   = '0;
          state_d = (HEADER_EN != 0) ? HEADER : BURST;
        end
      end
      HEADER: begin
        tx_din   = {HEADER_TAG[WORD_WIDTH-1:ID_W], grant_q};
        tx_empty = 1'b0;
        if (tx_re) state_d = BURST;
      end
      BURST: begin
        tx_din   = src_dout[grant_q*WORD_WIDTH +: WORD_WIDTH];
        tx_empty = src_empty[grant_q];
        if (src_empty[grant_q]) begin
          // Source ran dry: give up the grant rather than stall the link.
          state_d = IDLE;
        end else if (tx_re) begin
          src_re[grant_q] = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts in the same cycle: no word is offered or popped.
    if (!rst_n) begin
      tx_empty = 1'b1;
      src_re   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(NUM_CH - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_valid = (state_q != IDLE);
  assign grant_id    = grant_q;

endmodule
